// File: rtl/game_pkg.sv
// Shared types and constants for the tank-game score/HP controller.
//   state_t   : game sequencing states (IDLE/PLAY/OVER)
//   HP_W      : HP counter width
//   SCORE_W   : score counter width
//   NUM_TANKS : number of enemy tanks reporting kills
//   LED_W     : width of the HP bar on the board LEDs
//   hp_bar()  : thermometer code, bit k set iff hp > k
package game_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        OVER = 2'd2
    } state_t;

    localparam int unsigned HP_W      = 3;
    localparam int unsigned SCORE_W   = 7;
    localparam int unsigned NUM_TANKS = 4;
    localparam int unsigned LED_W     = 5;

    function automatic logic [LED_W-1:0] hp_bar(input logic [HP_W-1:0] hp);
        logic [LED_W-1:0] bar;
        bar = '0;
        for (int unsigned k = 0; k < LED_W; k++) begin
            bar[k] = (32'(hp) > k);
        end
        return bar;
    endfunction

endpackage

// File: rtl/rr_arb4.sv
// 4-way round-robin arbiter.
//   clk, rst : clock, synchronous active-high reset (pointer -> 0)
//   req      : request vector
//   advance  : when high and a request is granted, pointer moves past it
//   grant    : combinational one-hot grant (0 if no request)
module rr_arb4
    import game_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_TANKS-1:0] req,
    input  logic                 advance,
    output logic [NUM_TANKS-1:0] grant
);

    logic [1:0] ptr;
    logic [1:0] idx;
    logic [1:0] gidx;
    logic       found;

    // Scan starting at ptr, wrapping; first set request wins.
    always_comb begin
        grant = '0;
        found = 1'b0;
        gidx  = '0;
        idx   = '0;
        for (int unsigned k = 0; k < NUM_TANKS; k++) begin
            idx = ptr + 2'(k);
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                gidx       = idx;
                found      = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (advance && found) begin
            ptr <= gidx + 2'd1;
        end
    end

endmodule

// File: rtl/score_hp_arbiter.sv
// Score/HP controller: serialises enemy kill events through a round-robin
// arbiter into a saturating score, tracks player HP with bonus lives, and
// sequences IDLE/PLAY/OVER.
//   clk, rst   : clock, synchronous active-high reset
//   game_en    : level, high = play; low returns to IDLE and reloads
//   kill_pulse : one-cycle kill event per enemy tank
//   hit_pulse  : one-cycle player-hit event
//   score      : saturating score 0..SCORE_MAX
//   HP_value   : player HP 0..HP_MAX
//   led        : HP bar, one cycle behind HP_value
//   game_over  : high in OVER
//   grant      : registered one-hot of the kill scored next edge
//   drop_err   : sticky, a kill event was lost
module score_hp_arbiter
    import game_pkg::*;
#(
    parameter int unsigned HP_INIT    = 5,
    parameter int unsigned HP_MAX     = 5,
    parameter int unsigned BONUS_STEP = 10,
    parameter int unsigned SCORE_MAX  = 99
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 game_en,
    input  logic [NUM_TANKS-1:0] kill_pulse,
    input  logic                 hit_pulse,
    output logic [SCORE_W-1:0]   score,
    output logic [HP_W-1:0]      HP_value,
    output logic [LED_W-1:0]     led,
    output logic                 game_over,
    output logic [NUM_TANKS-1:0] grant,
    output logic                 drop_err
);

    state_t               state;
    logic [NUM_TANKS-1:0] pending;
    logic [NUM_TANKS-1:0] arb_grant;
    logic                 advance;
    logic                 score_bump;
    logic                 bonus;
    logic [SCORE_W-1:0]   score_next;

    rr_arb4 u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (pending),
        .advance (advance),
        .grant   (arb_grant)
    );

    // grant is registered, so the score increments one edge after the
    // arbiter decision; pointer only moves when that grant is registered.
    always_comb begin
        advance    = (state == PLAY) && game_en && (HP_value != '0);
        score_next = score + SCORE_W'(1);
        score_bump = (state == PLAY) && (grant != '0) &&
                     (score < SCORE_W'(SCORE_MAX));
        bonus      = score_bump &&
                     ((score_next % SCORE_W'(BONUS_STEP)) == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            score     <= '0;
            HP_value  <= HP_W'(HP_INIT);
            led       <= hp_bar(HP_W'(HP_INIT));
            game_over <= 1'b0;
            grant     <= '0;
            pending   <= '0;
            drop_err  <= 1'b0;
        end else begin
            led <= hp_bar(HP_value);
            if (!game_en || state == IDLE) begin
                // Reload happens both on leaving any state and on start.
                state     <= game_en ? PLAY : IDLE;
                score     <= '0;
                HP_value  <= HP_W'(HP_INIT);
                game_over <= 1'b0;
                grant     <= '0;
                pending   <= '0;
                drop_err  <= 1'b0;
            end else begin
                case (state)
                    PLAY: begin
                        if (score_bump) score <= score_next;
                        if (HP_value == '0) begin
                            state     <= OVER;
                            game_over <= 1'b1;
                            grant     <= '0;
                        end else begin
                            grant   <= arb_grant;
                            // A re-pulse on the bit being granted is a new event.
                            pending <= (pending & ~arb_grant) | kill_pulse;
                            if ((kill_pulse & pending & ~arb_grant) != '0)
                                drop_err <= 1'b1;
                            if (bonus && !hit_pulse) begin
                                if (HP_value < HP_W'(HP_MAX))
                                    HP_value <= HP_value + HP_W'(1);
                            end else if (hit_pulse && !bonus) begin
                                HP_value <= HP_value - HP_W'(1);
                            end
                        end
                    end
                    OVER: begin
                        grant <= '0;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_score_hp_arbiter.sv
// Directed testbench for score_hp_arbiter: hand-computed expectations.
module tb_score_hp_arbiter;
    import game_pkg::*;

    logic                 clk;
    logic                 rst;
    logic                 game_en;
    logic [NUM_TANKS-1:0] kill_pulse;
    logic                 hit_pulse;
    logic [SCORE_W-1:0]   score;
    logic [HP_W-1:0]      hp_value;
    logic [LED_W-1:0]     led;
    logic                 game_over;
    logic [NUM_TANKS-1:0] grant;
    logic                 drop_err;

    int checks = 0;
    int errors = 0;

    score_hp_arbiter #(
        .HP_INIT    (5),
        .HP_MAX     (5),
        .BONUS_STEP (10),
        .SCORE_MAX  (99)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .game_en    (game_en),
        .kill_pulse (kill_pulse),
        .hit_pulse  (hit_pulse),
        .score      (score),
        .HP_value   (hp_value),
        .led        (led),
        .game_over  (game_over),
        .grant      (grant),
        .drop_err   (drop_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Inputs set before step are sampled at its edge; outputs read #1 later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start();
        rst = 1'b1; game_en = 1'b0; kill_pulse = '0; hit_pulse = 1'b0;
        step();
        rst = 1'b0; game_en = 1'b1;
        step();
    endtask

    task automatic kill_one(input logic [NUM_TANKS-1:0] bits);
        kill_pulse = bits;
        step();
        kill_pulse = '0;
        step();
        step();
    endtask

    task automatic hit();
        hit_pulse = 1'b1;
        step();
        hit_pulse = 1'b0;
    endtask

    initial begin
        rst = 1'b1; game_en = 1'b0; kill_pulse = '0; hit_pulse = 1'b0;
        step();
        check("rst_score", score, 0);
        check("rst_hp", hp_value, 5);
        check("rst_led", led, 5'b11111);
        check("rst_over", game_over, 0);
        check("rst_grant", grant, 0);
        check("rst_drop", drop_err, 0);

        // single kill on tank 2
        start();
        kill_pulse = 4'b0100;
        step();
        kill_pulse = '0;
        check("k1_nogrant_yet", grant, 0);
        step();
        check("k1_grant", grant, 4'b0100);
        check("k1_score_pre", score, 0);
        step();
        check("k1_score", score, 1);
        check("k1_hp", hp_value, 5);
        check("k1_grant_clr", grant, 0);

        // all four at once
        start();
        kill_pulse = 4'b1111;
        step();
        kill_pulse = '0;
        step(); check("rr_g0", grant, 4'b0001);
        step(); check("rr_g1", grant, 4'b0010);
        step(); check("rr_g2", grant, 4'b0100);
        step(); check("rr_g3", grant, 4'b1000);
        step(); check("rr_idle", grant, 0);
        check("rr_score", score, 4);

        // hits, led lag, bonus at 10
        start();
        hit(); check("h1", hp_value, 4);
        hit(); check("h2", hp_value, 3);
        hit(); check("h3", hp_value, 2);
        check("led_lag", led, 5'b00111);
        step(); check("led_2", led, 5'b00011);
        for (int i = 0; i < 9; i++) kill_one(4'b0001);
        check("b_score9", score, 9);
        check("b_hp9", hp_value, 2);
        kill_one(4'b0010);
        check("b_score10", score, 10);
        check("b_hp10", hp_value, 3);

        // bonus and hit on the same edge cancel
        start();
        hit();
        for (int i = 0; i < 9; i++) kill_one(4'b0001);
        check("c_hp", hp_value, 4);
        kill_pulse = 4'b0001;
        step();
        kill_pulse = '0;
        step();
        hit_pulse = 1'b1;
        step();
        hit_pulse = 1'b0;
        check("c_score", score, 10);
        check("c_hp_net", hp_value, 4);

        // game over
        start();
        kill_one(4'b0001);
        kill_one(4'b0010);
        for (int i = 0; i < 4; i++) hit();
        check("o_hp1", hp_value, 1);
        hit();
        check("o_hp0", hp_value, 0);
        check("o_notyet", game_over, 0);
        step();
        check("o_over", game_over, 1);
        kill_one(4'b0001);
        hit();
        step();
        check("o_frozen_score", score, 2);
        check("o_frozen_hp", hp_value, 0);
        game_en = 1'b0;
        step();
        check("o_idle_over", game_over, 0);
        game_en = 1'b1;
        step();
        check("o_restart_score", score, 0);
        check("o_restart_hp", hp_value, 5);

        // lost event on tank 2
        start();
        kill_pulse = 4'b0111;
        step();
        kill_pulse = 4'b0100;
        step();
        kill_pulse = '0;
        check("d_drop", drop_err, 1);
        step(); step(); step(); step();
        check("d_score", score, 3);
        check("d_grant", grant, 0);

        // re-pulse on the granted bit is kept, no drop
        start();
        kill_pulse = 4'b0100;
        step();
        step();
        kill_pulse = '0;
        check("r_grant1", grant, 4'b0100);
        step();
        check("r_grant2", grant, 4'b0100);
        step(); step();
        check("r_score", score, 2);
        check("r_nodrop", drop_err, 0);

        // game_en drop mid-drain
        start();
        kill_pulse = 4'b1111;
        step();
        kill_pulse = '0;
        step();
        game_en = 1'b0;
        step();
        check("e_score", score, 0);
        check("e_grant", grant, 0);
        game_en = 1'b1;
        step(); step(); step(); step();
        check("e_score_after", score, 0);
        check("e_grant_after", grant, 0);

        // rst resets the pointer mid-arbitration
        start();
        kill_pulse = 4'b1111;
        step();
        kill_pulse = '0;
        step();
        step();
        rst = 1'b1;
        step();
        check("p_grant_rst", grant, 0);
        rst = 1'b0; game_en = 1'b1;
        step();
        kill_pulse = 4'b1111;
        step();
        kill_pulse = '0;
        step();
        check("p_ptr0", grant, 4'b0001);

        // score saturation, bonus at HP_MAX discarded
        start();
        for (int i = 0; i < 99; i++) kill_one(4'b1000);
        check("s_score99", score, 99);
        check("s_hp", hp_value, 5);
        kill_one(4'b0001);
        check("s_sat", score, 99);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
